instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Fetch stage of the RISC-V core: holds the architectural PC, fetches 32-bit words over a req/gnt/rvalid instruction-memory handshake, and presents one instruction at a time to the decode/control stage.
- Computes the next PC from the retiring instruction's `branch`/`jal`/`jalr` controls, the branch outcome and the jalr target.
- Provides `pc_plus4` for link write-back and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value on `instr` when no fetched word has been captured (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  32  fetch address; equals current PC; stable while `imem_req` is high
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response word valid
- imem_rdata  in  32  response word
- instr  out  32  registered instruction to decode
- instr_pc  out  32  PC of `instr`
- pc_plus4  out  32  `instr_pc + 4`, mod 2^32
- instr_valid  out  1  `instr` is valid for execution
- instr_ready  in  1  downstream retires `instr` this cycle
- branch, jal, jalr  in  1 each  decode controls for the current `instr`
- branch_taken  in  1  branch comparison result for the current `instr`
- imm  in  32  sign-extended immediate of the current `instr`
- jalr_target  in  32  ALU result (rs1+imm) for jalr
- fetch_error  out  1  sticky: misaligned next-PC detected
- instret  out  32  retired-instruction counter

## Operation
- States: BOOT, FETCH, WAIT, ISSUE, TRAP.
- BOOT: after reset. No request. Moves to FETCH on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=pc.
  - `imem_gnt`=1 -> WAIT.
  - Otherwise stay; address held.
  - `imem_rvalid` here is ignored.
- WAIT: on `imem_rvalid`=1, capture `instr`<=`imem_rdata` and `instr_pc`<=pc, then go to ISSUE. Otherwise stay; no timeout.
- ISSUE: `instr_valid`=1. On `instr_ready`=1 (retire):
  - next_pc, by priority:
    - `jalr`: `{jalr_target[31:1],1'b0}`
    - else `jal`: pc+imm
    - else `branch && branch_taken`: pc+imm
    - else pc+4
    - All adds are 32-bit, wrap mod 2^32.
  - If next_pc[1:0]!=0: go to TRAP; `fetch_error`<=1; pc unchanged.
  - Else: pc<=next_pc and go to FETCH.
  - `instret`<=`instret`+1 (wraps) in both cases.
  - If `instr_ready`=0: hold all state; the redirect inputs are don't-care.
- TRAP: no requests, `instr_valid`=0, all inputs ignored. Left only by reset.
- `pc_plus4` = `instr_pc`+4, combinational.
- Redirect controls are sampled only in ISSUE with `instr_ready`=1.
- Reset values (immediate on `rst_n` low, any state): state BOOT, pc=RESET_PC, `instr`=NOP_INSTR, `instr_pc`=RESET_PC, `instr_valid`=0, `imem_req`=0, `fetch_error`=0, `instret`=0.
- Reset mid-transaction abandons any outstanding response. The memory shares `rst_n` and drops it too.

## Timing
- Cycle 0 is the first edge with `rst_n` high: BOOT. Cycle 1: FETCH with `imem_req`=1.
- Memory contract: `imem_rvalid` for a granted request arrives no earlier than the cycle after `imem_gnt`. Exactly one response per grant.
- Best case (gnt in FETCH cycle, rvalid next cycle, ready in first ISSUE cycle): 3 cycles per instruction.
  - Cycle N: FETCH+gnt. Cycle N+1: WAIT+rvalid. Cycle N+2: ISSUE, `instr_valid`=1, retire. Cycle N+3: FETCH of next_pc.
- `instr_valid` drops the cycle after retirement.
- `instr`/`instr_pc` stay stable from entry to ISSUE until the next rvalid capture.
- `fetch_error` rises the cycle after the misaligned retire.

## Test plan
- Reset release, gnt=1 always, rvalid one cycle later, ready=1, no jumps -> `imem_addr` 0x0, 0x4, 0x8 in cycles 1, 4, 7; `instret`=3 after third retire; `instr_valid` never high in BOOT/FETCH/WAIT.
- Memory stalls: gnt low 3 cycles, rvalid 4 cycles after gnt, ready low 2 ISSUE cycles -> `imem_addr` stable while req high; `instr` constant; single retire counted.
- Redirects at pc=0x100:
  - taken branch, imm=0xFFFF_FFF0 -> next fetch 0xF0
  - branch not taken -> 0x104
  - jal imm=0x20 -> 0x120
  - jalr, jalr_target=0x2003 -> 0x2002 misaligned -> TRAP, `fetch_error`=1, no further `imem_req`
- Priority and wrap: jal and jalr both high, jalr_target=0x400 -> 0x400. pc=0xFFFF_FFFC, plain retire -> next fetch 0x0, `pc_plus4`=0x0.
- Async reset asserted in WAIT and in TRAP -> outputs return to reset values the same cycle, without a clock edge; `fetch_error` cleared; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one 32-bit word
// at a time over a req/gnt/rvalid handshake, presents it to decode, and
// computes the next PC when decode retires the instruction.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] jalr_target,
  output logic        fetch_error,
  output logic [31:0] instret
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_TRAP  = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_imm;
  logic [31:0] next_pc;
  logic        retire;
  logic        misaligned;

  // Only one instruction is ever in flight, so pc equals instr_pc while in
  // ISSUE and the redirect arithmetic can use pc directly.
  assign retire     = (state == S_ISSUE) && instr_ready;
  assign pc_imm     = pc + imm;
  assign misaligned = (next_pc[1:0] != 2'b00);

  // Next-PC select: jalr beats jal beats taken branch beats fall-through.
  always_comb begin
    next_pc = pc + 32'd4;
    if (jalr)                       next_pc = {jalr_target[31:1], 1'b0};
    else if (jal)                   next_pc = pc_imm;
    else if (branch && branch_taken) next_pc = pc_imm;
  end

  // Fetch sequencing; TRAP is a sink left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      case (state)
        S_BOOT:  state <= S_FETCH;
        S_FETCH: if (imem_gnt)    state <= S_WAIT;
        S_WAIT:  if (imem_rvalid) state <= S_ISSUE;
        S_ISSUE: if (retire)      state <= misaligned ? S_TRAP : S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_BOOT;
      endcase
    end
  end

  // Architectural PC: advances only on an aligned retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pc <= RESET_PC;
    else if (retire && !misaligned) pc <= next_pc;
  end

  // Capture the response word and the PC it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      instr_pc <= RESET_PC;
    end else if (state == S_WAIT && imem_rvalid) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

  // Sticky misalignment flag and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_error <= 1'b0;
      instret     <= 32'd0;
    end else if (retire) begin
      instret <= instret + 32'd1;
      if (misaligned) fetch_error <= 1'b1;
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_ISSUE);
  assign pc_plus4    = instr_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios pinned with literal values,
// then randomized memory/decode behaviour compared every cycle to a
// transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, instr_pc, pc_plus4, imm, jalr_target, instret;
  logic        instr_valid, instr_ready, branch, jal, jalr, branch_taken;
  logic        fetch_error;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .jal(jal), .jalr(jalr), .branch_taken(branch_taken),
    .imm(imm), .jalr_target(jalr_target),
    .fetch_error(fetch_error), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model phases named after the stage's observable phases
  localparam int P_BOOT = 0, P_FETCH = 1, P_WAIT = 2, P_ISSUE = 3, P_TRAP = 4;
  int          ph;
  logic [31:0] m_pc, m_instr, m_ipc, m_instret;
  logic        m_err;

  // Memory model: at most one outstanding response
  bit          pend;
  int          cnt;
  logic [31:0] paddr;

  // Directed-mode knobs
  bit          directed;
  logic        k_br, k_bt, k_jal, k_jalr;
  logic [31:0] k_imm, k_tgt;

  int          cyc;
  int          gcyc[$];
  logic [31:0] gaddr[$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, ph == P_FETCH});
    if (ph == P_FETCH) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, ph == P_ISSUE});
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("pc_plus4", pc_plus4, m_ipc + 32'd4);
    chk("fetch_error", {31'd0, fetch_error}, {31'd0, m_err});
    chk("instret", instret, m_instret);
  endtask

  task automatic drive();
    if (directed) begin
      imem_gnt = 1'b1; instr_ready = 1'b1;
      branch = k_br; branch_taken = k_bt; jal = k_jal; jalr = k_jalr;
      imm = k_imm; jalr_target = k_tgt;
    end else begin
      int k;
      imem_gnt     = ($urandom_range(0, 2) != 0);
      instr_ready  = ($urandom_range(0, 2) != 0);
      branch       = ($urandom_range(0, 3) == 0);
      branch_taken = $urandom_range(0, 1) != 0;
      jal          = ($urandom_range(0, 3) == 0);
      jalr         = ($urandom_range(0, 5) == 0);
      k            = int'($urandom_range(0, 127)) - 64;
      imm          = 32'(k * 4);
      if ($urandom_range(0, 49) == 0) imm[1] = 1'b1;
      jalr_target  = $urandom;
      if ($urandom_range(0, 49) != 0) jalr_target[1] = 1'b0;
    end
    if (pend && cnt == 0) begin
      imem_rvalid = 1'b1; imem_rdata = memword(paddr);
    end else if (!directed && !pend && ph == P_FETCH && $urandom_range(0, 7) == 0) begin
      imem_rvalid = 1'b1; imem_rdata = $urandom;   // stray response, must be ignored
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
  endtask

  task automatic model_update();
    logic [31:0] nxt;
    // memory side first, it looks at the phase before this edge
    if (pend) begin
      if (cnt == 0) pend = 0; else cnt--;
    end
    if (ph == P_FETCH && imem_gnt) begin
      pend = 1; paddr = m_pc;
      cnt = directed ? 0 : int'($urandom_range(0, 4));
    end
    case (ph)
      P_BOOT:  ph = P_FETCH;
      P_FETCH: if (imem_gnt) ph = P_WAIT;
      P_WAIT:  if (imem_rvalid) begin m_instr = imem_rdata; m_ipc = m_pc; ph = P_ISSUE; end
      P_ISSUE: if (instr_ready) begin
        if (jalr)                         nxt = jalr_target & 32'hFFFF_FFFE;
        else if (jal || (branch && branch_taken)) nxt = m_pc + imm;
        else                              nxt = m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        if (nxt % 4 != 0) begin m_err = 1'b1; ph = P_TRAP; end
        else begin m_pc = nxt; ph = P_FETCH; end
      end
      default: ;
    endcase
  endtask

  // One clock: compare at the negedge, drive, advance model at the posedge.
  task automatic step();
    check_all();
    drive();
    if (imem_req && imem_gnt) begin gcyc.push_back(cyc); gaddr.push_back(imem_addr); end
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  // Called at a negedge; reset values must appear without any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_fetch_error", {31'd0, fetch_error}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    ph = P_BOOT; m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_instret = 0; m_err = 0;
    pend = 0; cnt = 0;
    imem_gnt = 0; imem_rvalid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    gcyc.delete(); gaddr.delete();
  endtask

  task automatic knobs(input logic br, input logic bt, input logic j, input logic jr,
                       input logic [31:0] im, input logic [31:0] tg);
    k_br = br; k_bt = bt; k_jal = j; k_jalr = jr; k_imm = im; k_tgt = tg;
  endtask

  // Reset, then jal to 0x100; ends at the FETCH of 0x100.
  task automatic go_100();
    do_reset();
    knobs(0, 0, 1, 0, 32'h100, 32'h0);
    repeat (4) step();
    chk("at_0x100", imem_addr, 32'h100);
  endtask

  // From FETCH of 0x100, retire one instruction with the given controls.
  task automatic redirect(input string nm, input logic br, input logic bt, input logic j,
                          input logic jr, input logic [31:0] im, input logic [31:0] tg,
                          input logic [31:0] want);
    go_100();
    knobs(br, bt, j, jr, im, tg);
    repeat (3) step();
    chk(nm, imem_addr, want);
  endtask

  initial begin
    int tc;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
    branch = 0; jal = 0; jalr = 0; branch_taken = 0; imm = 0; jalr_target = 0;
    directed = 1; knobs(0, 0, 0, 0, 0, 0);
    cyc = 0; pend = 0; cnt = 0;
    @(negedge clk);

    // Straight-line fetch: grants at cycles 1, 4, 7 for 0x0, 0x4, 0x8
    do_reset();
    repeat (10) step();
    chk("grant_count", gcyc.size(), 3);
    if (gcyc.size() >= 3) begin
      chk("g0_cyc", gcyc[0], 1); chk("g0_addr", gaddr[0], 32'h0);
      chk("g1_cyc", gcyc[1], 4); chk("g1_addr", gaddr[1], 32'h4);
      chk("g2_cyc", gcyc[2], 7); chk("g2_addr", gaddr[2], 32'h8);
    end
    chk("instret_3", instret, 32'd3);
    chk("instr_word", instr, memword(32'h8));

    redirect("br_taken", 1, 1, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'hF0);
    redirect("br_not_taken", 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'h104);
    redirect("jal_0x20", 0, 0, 1, 0, 32'h20, 32'h0, 32'h120);
    redirect("jal_jalr_prio", 0, 0, 1, 1, 32'h20, 32'h400, 32'h400);

    // Misaligned jalr -> trap, then reset while trapped
    go_100();
    knobs(0, 0, 0, 1, 32'h0, 32'h2003);
    repeat (3) step();
    chk("trap_error", {31'd0, fetch_error}, 32'd1);
    chk("trap_no_req", {31'd0, imem_req}, 32'd0);
    repeat (4) step();
    do_reset();

    // PC wrap: jalr to 0xFFFF_FFFC, plain retire wraps to 0x0
    knobs(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC);
    repeat (4) step();
    chk("at_top", imem_addr, 32'hFFFF_FFFC);
    knobs(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) step();
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    step();
    chk("wrap_fetch", imem_addr, 32'h0);

    // Reset in WAIT, fetch restarts at RESET_PC
    do_reset();
    repeat (2) step();
    chk("wait_no_valid", {31'd0, instr_valid}, 32'd0);
    do_reset();
    repeat (2) step();
    chk("restart_addr", gaddr.size() > 0 ? gaddr[0] : 32'hFFFF_FFFF, 32'h0);

    // Randomized traffic against the model
    directed = 0;
    tc = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (ph == P_TRAP) tc++;
      if (tc > 6 || $urandom_range(0, 399) == 0) begin
        do_reset();
        tc = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
